// File: rtl/hex_display_pkg.sv
// Shared definitions for the hex display controller: register map, CTRL field
// positions, special glyphs and the double-dabble FSM state type.
package hex_display_pkg;

    localparam logic [1:0] ADDR_VALUE  = 2'd0;
    localparam logic [1:0] ADDR_CTRL   = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_RSVD   = 2'd3;

    localparam int CTRL_MODE_BIT  = 0;
    localparam int CTRL_LZB_BIT   = 1;
    localparam int CTRL_EN_LSB    = 8;
    localparam int CTRL_BLINK_LSB = 16;

    // Active-low, bit6 = g .. bit0 = a
    localparam logic [6:0] GLYPH_DASH  = 7'h3F;
    localparam logic [6:0] GLYPH_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } dd_state_t;

endpackage

// File: rtl/seg7_encode.sv
// Combinational nibble to seven-segment glyph, active-low, bit6 = g .. bit0 = a.
module seg7_encode (
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = 7'h7F;
        case (nibble)
            4'h0: glyph = 7'h40;
            4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;
            4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;
            4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;
            4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;
            4'hF: glyph = 7'h0E;
            default: glyph = 7'h7F;
        endcase
    end

endmodule

// File: rtl/hex_display_ctrl.sv
// Avalon-MM seven-segment controller: hex or double-dabble decimal display with
// leading-zero blanking, per-digit enable/blink and decimal overflow dashes.
module hex_display_ctrl
    import hex_display_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int DATA_WIDTH = 24,
    parameter int BLINK_DIV  = 25000000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                    clk_clk,
    input  logic                    reset_reset_n,
    input  logic [1:0]              avs_address,
    input  logic                    avs_write,
    input  logic [31:0]             avs_writedata,
    input  logic                    avs_read,
    output logic [31:0]             avs_readdata,
    output logic [7*NUM_DIGITS-1:0] hex_o
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [DATA_WIDTH-1:0] value_q;
    logic                  mode_q, lzb_q, ovf_q;
    logic [NUM_DIGITS-1:0] en_q, blink_q;
    logic [BCD_W-1:0]      nib_q;

    dd_state_t             state_q, state_d;
    logic                  busy, dd_load;
    logic [DATA_WIDTH-1:0] sh_q;
    logic [BCD_W-1:0]      bcd_q, bcd_adj;
    logic                  ovf_acc_q;
    logic [CNT_W-1:0]      cnt_q;

    logic [BLK_W-1:0]      blk_cnt_q;
    logic                  phase_q;

    logic                  wr_value, wr_ctrl, start, abort;
    logic [DATA_WIDTH-1:0] start_value;
    logic [31:0]           rd_mux;
    logic [6:0]            glyph [NUM_DIGITS];
    logic [7*NUM_DIGITS-1:0] hex_d;
    logic                  unused_wd;

    function automatic logic [BCD_W-1:0] hex_nibbles(input logic [DATA_WIDTH-1:0] v);
        logic [BCD_W+DATA_WIDTH-1:0] ext;
        logic [BCD_W-1:0]            r;
        ext = {{BCD_W{1'b0}}, v};
        r   = '0;
        for (int d = 0; d < NUM_DIGITS; d++)
            if (d < DATA_WIDTH / 4) r[4*d +: 4] = ext[4*d +: 4];
        return r;
    endfunction

    function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int d = 0; d < NUM_DIGITS; d++)
            if (b[4*d +: 4] >= 4'd5) r[4*d +: 4] = b[4*d +: 4] + 4'd3;
        return r;
    endfunction

    assign unused_wd   = ^avs_writedata;
    assign wr_value    = avs_write && (avs_address == ADDR_VALUE);
    assign wr_ctrl     = avs_write && (avs_address == ADDR_CTRL);
    assign start       = (wr_value && mode_q) || (wr_ctrl && avs_writedata[CTRL_MODE_BIT]);
    assign abort       = wr_ctrl && !avs_writedata[CTRL_MODE_BIT];
    assign start_value = wr_value ? avs_writedata[DATA_WIDTH-1:0] : value_q;
    assign bcd_adj     = dd_adjust(bcd_q);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) state_q <= ST_IDLE;
        else                state_q <= state_d;
    end

    // A new start always wins, so a restart never exposes a partial result
    always_comb begin
        state_d = state_q;
        if (start)      state_d = ST_SHIFT;
        else if (abort) state_d = ST_IDLE;
        else begin
            case (state_q)
                ST_SHIFT: if (cnt_q == CNT_W'(DATA_WIDTH - 1)) state_d = ST_DONE;
                ST_DONE:  state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy    = (state_q != ST_IDLE);
        dd_load = (state_q == ST_DONE) && !start && !abort;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sh_q      <= '0;
            bcd_q     <= '0;
            ovf_acc_q <= 1'b0;
            cnt_q     <= '0;
        end else if (start) begin
            sh_q      <= start_value;
            bcd_q     <= '0;
            ovf_acc_q <= 1'b0;
            cnt_q     <= '0;
        end else if (state_q == ST_SHIFT) begin
            {bcd_q, sh_q} <= {bcd_adj[BCD_W-2:0], sh_q, 1'b0};
            ovf_acc_q     <= ovf_acc_q | bcd_adj[BCD_W-1];
            cnt_q         <= cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            value_q <= '0;
            mode_q  <= 1'b0;
            lzb_q   <= 1'b0;
            en_q    <= '1;
            blink_q <= '0;
            ovf_q   <= 1'b0;
            nib_q   <= '0;
        end else begin
            if (wr_value) value_q <= avs_writedata[DATA_WIDTH-1:0];
            if (wr_ctrl) begin
                mode_q  <= avs_writedata[CTRL_MODE_BIT];
                lzb_q   <= avs_writedata[CTRL_LZB_BIT];
                en_q    <= avs_writedata[CTRL_EN_LSB +: NUM_DIGITS];
                blink_q <= avs_writedata[CTRL_BLINK_LSB +: NUM_DIGITS];
            end
            if (wr_value && !mode_q) begin
                nib_q <= hex_nibbles(avs_writedata[DATA_WIDTH-1:0]);
            end else if (abort) begin
                nib_q <= hex_nibbles(value_q);
                ovf_q <= 1'b0;
            end else if (dd_load) begin
                nib_q <= bcd_q;
                ovf_q <= ovf_acc_q;
            end
        end
    end

    // Free-running blink timebase, untouched by register writes
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            blk_cnt_q <= '0;
            phase_q   <= 1'b1;
        end else if (blk_cnt_q == BLK_W'(BLINK_DIV - 1)) begin
            blk_cnt_q <= '0;
            phase_q   <= ~phase_q;
        end else begin
            blk_cnt_q <= blk_cnt_q + BLK_W'(1);
        end
    end

    always_comb begin
        rd_mux = '0;
        case (avs_address)
            ADDR_VALUE: rd_mux[DATA_WIDTH-1:0] = value_q;
            ADDR_CTRL: begin
                rd_mux[CTRL_MODE_BIT]                 = mode_q;
                rd_mux[CTRL_LZB_BIT]                  = lzb_q;
                rd_mux[CTRL_EN_LSB +: NUM_DIGITS]     = en_q;
                rd_mux[CTRL_BLINK_LSB +: NUM_DIGITS]  = blink_q;
            end
            ADDR_STATUS: rd_mux[1:0] = {ovf_q, busy};
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n)  avs_readdata <= '0;
        else if (avs_read)   avs_readdata <= rd_mux;
    end

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_enc
        seg7_encode u_enc (
            .nibble (nib_q[4*gi +: 4]),
            .glyph  (glyph[gi])
        );
    end

    // Leading-zero run is tracked from the top digit down, including the digit itself
    always_comb begin
        logic       zero_run;
        logic [6:0] g;
        hex_d    = '0;
        zero_run = 1'b1;
        g        = GLYPH_BLANK;
        for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
            zero_run = zero_run && (nib_q[4*d +: 4] == 4'h0);
            if (!en_q[d])                        g = GLYPH_BLANK;
            else if (blink_q[d] && !phase_q)     g = GLYPH_BLANK;
            else if (ovf_q && mode_q)            g = GLYPH_DASH;
            else if (lzb_q && zero_run && d != 0) g = GLYPH_BLANK;
            else                                 g = glyph[d];
            hex_d[7*d +: 7] = ACTIVE_LOW ? g : ~g;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) hex_o <= {(7*NUM_DIGITS){ACTIVE_LOW}};
        else                hex_o <= hex_d;
    end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Bench for hex_display_ctrl: directed register traffic, an arithmetic display
// model compared every cycle, and literal expectations for key scenarios.
module tb_hex_display_ctrl;

    localparam int N    = 6;
    localparam int DW   = 24;
    localparam int BDIV = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  avs_address;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic [7*N-1:0] hex_o;

    hex_display_ctrl #(
        .NUM_DIGITS (N),
        .DATA_WIDTH (DW),
        .BLINK_DIV  (BDIV),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .avs_address   (avs_address),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_read      (avs_read),
        .avs_readdata  (avs_readdata),
        .hex_o         (hex_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Behavioural model state
    int          m_value;
    bit          m_mode, m_lzb, m_ovf, m_pend_ovf;
    bit [N-1:0]  m_en, m_blink;
    int          m_nib [N];
    int          m_pend_nib [N];
    int          m_timer;
    int          m_edges;
    bit          m_phase, m_touched, model_live;
    logic [7*N-1:0] exp_hex;
    logic [31:0]    exp_rd;

    function automatic logic [7*N-1:0] render(input bit ph);
        logic [7*N-1:0] r;
        logic [6:0]     g;
        bit             zero_above;
        r = '0;
        for (int d = 0; d < N; d++) begin
            zero_above = 1'b1;
            for (int j = d; j < N; j++) if (m_nib[j] != 0) zero_above = 1'b0;
            if (!m_en[d])                          g = 7'h7F;
            else if (m_blink[d] && !ph)            g = 7'h7F;
            else if (m_ovf && m_mode)              g = 7'h3F;
            else if (m_lzb && zero_above && d != 0) g = 7'h7F;
            else                                   g = GLYPH[m_nib[d]];
            r[7*d +: 7] = g;
        end
        return r;
    endfunction

    task automatic model_hexload(input int v);
        for (int d = 0; d < N; d++) m_nib[d] = (d < DW / 4) ? ((v >> (4 * d)) & 15) : 0;
    endtask

    task automatic model_start(input int v);
        int pw;
        pw = 1;
        for (int d = 0; d < N; d++) begin
            m_pend_nib[d] = (v / pw) % 10;
            pw = pw * 10;
        end
        m_pend_ovf = (v >= pw);
        m_timer    = DW + 1;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_value = 0; m_mode = 0; m_lzb = 0; m_ovf = 0; m_pend_ovf = 0;
            m_en = '1; m_blink = '0; m_timer = 0; m_edges = 0;
            for (int d = 0; d < N; d++) begin m_nib[d] = 0; m_pend_nib[d] = 0; end
            exp_hex = '1; exp_rd = '0; model_live = 1'b1;
        end else begin
            m_phase = ((m_edges / BDIV) % 2) == 0;
            exp_hex = render(m_phase);
            if (avs_read) begin
                case (avs_address)
                    2'd0: exp_rd = 32'(m_value);
                    2'd1: exp_rd = (32'(m_blink) << 16) | (32'(m_en) << 8) | (32'(m_lzb) << 1) | 32'(m_mode);
                    2'd2: exp_rd = {30'd0, m_ovf, (m_timer > 0)};
                    default: exp_rd = 32'd0;
                endcase
            end
            m_edges++;
            m_touched = 1'b0;
            if (avs_write && avs_address == 2'd0) begin
                m_value = int'(avs_writedata[DW-1:0]);
                if (m_mode) begin model_start(m_value); m_touched = 1'b1; end
                else model_hexload(m_value);
            end else if (avs_write && avs_address == 2'd1) begin
                m_mode  = avs_writedata[0];
                m_lzb   = avs_writedata[1];
                m_en    = avs_writedata[8 +: N];
                m_blink = avs_writedata[16 +: N];
                m_touched = 1'b1;
                if (avs_writedata[0]) model_start(m_value);
                else begin m_timer = 0; model_hexload(m_value); m_ovf = 0; end
            end
            if (!m_touched && m_timer > 0) begin
                m_timer--;
                if (m_timer == 0) begin
                    for (int d = 0; d < N; d++) m_nib[d] = m_pend_nib[d];
                    m_ovf = m_pend_ovf;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && model_live) begin
            checks++;
            if (hex_o !== exp_hex) begin
                errors++;
                if (errors < 40) $display("FAIL cyc_hex_o t=%0t actual=%h required=%h", $time, hex_o, exp_hex);
            end
            checks++;
            if (avs_readdata !== exp_rd) begin
                errors++;
                if (errors < 40) $display("FAIL cyc_readdata t=%0t actual=%h required=%h", $time, avs_readdata, exp_rd);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        avs_address = a; avs_writedata = d; avs_write = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        avs_address = a; avs_read = 1'b1;
        @(negedge clk);
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    localparam logic [7*N-1:0] ALL_ZERO = {6{7'h40}};
    localparam logic [7*N-1:0] ALL_OFF  = {6{7'h7F}};

    initial begin
        logic [31:0] r;
        int busy_cnt, blanks, steady_bad;
        bit done;

        rst_n = 1'b0; avs_address = '0; avs_write = 1'b0; avs_writedata = '0; avs_read = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_hex_off", hex_o, ALL_OFF);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_hex", hex_o, ALL_ZERO);
        rd(2'd2, r); check("reset_status", r, 32'h0);
        rd(2'd1, r); check("reset_ctrl", r, 32'h0000_3F00);
        rd(2'd0, r); check("reset_value", r, 32'h0);
        rd(2'd3, r); check("rsvd_read", r, 32'h0);

        // Hex mode
        wr(2'd0, 32'h00AB_C123);
        check("hex_t1_old", hex_o, ALL_ZERO);
        @(negedge clk);
        check("hex_t2_new", hex_o, {7'h08, 7'h03, 7'h46, 7'h79, 7'h24, 7'h30});
        rd(2'd0, r); check("value_readback", r, 32'h00AB_C123);

        // Decimal mode
        wr(2'd1, 32'h0000_3F01);
        repeat (30) @(negedge clk);
        wr(2'd0, 32'd123456);
        avs_address = 2'd2; avs_read = 1'b1;
        busy_cnt = 0; done = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (avs_readdata[0]) busy_cnt++;
            else done = 1'b1;
        end
        avs_read = 1'b0;
        check("busy_cycles", busy_cnt, 25);
        repeat (3) @(negedge clk);
        check("dec_123456", hex_o, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02});
        rd(2'd2, r); check("dec_status_ok", r, 32'h0);

        // Overflow and restart
        wr(2'd0, 32'd1000000);
        repeat (30) @(negedge clk);
        check("ovf_dashes", hex_o, {6{7'h3F}});
        rd(2'd2, r); check("ovf_status", r, 32'h2);
        wr(2'd0, 32'd1000000);
        repeat (5) @(negedge clk);
        wr(2'd0, 32'd42);
        repeat (30) @(negedge clk);
        check("restart_42", hex_o, {7'h40, 7'h40, 7'h40, 7'h40, 7'h19, 7'h24});
        rd(2'd2, r); check("restart_status", r, 32'h0);
        wr(2'd1, 32'h0000_3F03);
        repeat (30) @(negedge clk);
        check("lzb_42", hex_o, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24});

        // Abort by clearing MODE mid-conversion
        wr(2'd1, 32'h0000_3F01);
        wr(2'd0, 32'h0000_0123);
        repeat (5) @(negedge clk);
        wr(2'd1, 32'h0000_3F00);
        @(negedge clk);
        check("abort_hex", hex_o, {7'h40, 7'h40, 7'h40, 7'h79, 7'h24, 7'h30});
        rd(2'd2, r); check("abort_status", r, 32'h0);

        // Blink on digit 0
        wr(2'd1, 32'h0001_3F00);
        @(negedge clk);
        blanks = 0; steady_bad = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (hex_o[6:0] == 7'h7F) blanks++;
            else if (hex_o[6:0] != 7'h30) steady_bad++;
            if (hex_o[41:7] != {7'h40, 7'h40, 7'h40, 7'h79, 7'h24}) steady_bad++;
        end
        check("blink_blank_cycles", blanks, 8);
        check("blink_others_steady", steady_bad, 0);

        // Digit enable
        wr(2'd1, 32'h0000_0500);
        @(negedge clk);
        check("enable_05", hex_o, {7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h7F, 7'h30});

        // Reset during SHIFT
        wr(2'd1, 32'h0000_3F01);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset_hex", hex_o, ALL_OFF);
        check("async_reset_rd", avs_readdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        rd(2'd2, r); check("reset_busy_clear", r, 32'h0);
        rd(2'd1, r); check("reset_ctrl_again", r, 32'h0000_3F00);
        check("reset_hex_zero", hex_o, ALL_ZERO);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
